// File: rtl/linear_layer_fifo_pkg.sv
// Shared constants and types for the Linear_Layer start-token FIFOs.
package linear_layer_fifo_pkg;

  localparam int START_FIFO_DATA_WIDTH = 1;
  localparam int START_FIFO_ADDR_WIDTH = 1;
  localparam int START_FIFO_DEPTH      = 2;

  typedef logic [START_FIFO_ADDR_WIDTH:0] fifo_cnt_t;

  // Per-cycle action after push/pop qualification.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_PUSH,
    OP_POP,
    OP_SHIFT
  } fifo_op_e;

endpackage

// File: rtl/linear_layer_start_token_srl.sv
// Shift-register token storage: writes enter at entry 0, reads are combinational by address.
module linear_layer_start_token_srl
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = START_FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = START_FIFO_ADDR_WIDTH,
  parameter int DEPTH      = START_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = DEPTH - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/linear_layer_start_token_fifo.sv
// Start-token FIFO: occupancy counter and full/empty flags around an SRL store.
// Optional START_FIFO_OCCUPANCY_EN adds the if_num_data_valid occupancy port.
module linear_layer_start_token_fifo
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = START_FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = START_FIFO_ADDR_WIDTH,
  parameter int DEPTH      = START_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
`ifdef START_FIFO_OCCUPANCY_EN
  ,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
`endif
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   cnt_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  push;
  logic                  pop;
  fifo_op_e              op;

  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read & if_read_ce & if_empty_n;

  always_comb begin
    op = OP_HOLD;
    if (push && pop) op = OP_SHIFT;
    else if (push)   op = OP_PUSH;
    else if (pop)    op = OP_POP;
  end

  always_comb begin
    cnt_next = cnt;
    case (op)
      OP_PUSH: cnt_next = cnt + CNT_ONE;
      OP_POP:  cnt_next = cnt - CNT_ONE;
      default: cnt_next = cnt;
    endcase
  end

  // Flags are registered from cnt_next so they line up with the new count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
    end else begin
      cnt        <= cnt_next;
      if_empty_n <= (cnt_next != '0);
      if_full_n  <= (cnt_next != CNT_MAX);
    end
  end

  // Head sits at cnt-1; a simultaneous push shifts the next-oldest token onto it.
  assign addr = (cnt == '0) ? '0 : ADDR_WIDTH'(cnt - CNT_ONE);

  linear_layer_start_token_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (push),
    .addr (addr),
    .din  (if_din),
    .dout (if_dout)
  );

`ifdef START_FIFO_OCCUPANCY_EN
  assign if_num_data_valid = cnt;
`endif

endmodule

// File: tb/tb_linear_layer_start_token_fifo.sv
// Self-checking bench: queue-based token model plus directed boundary cases and random traffic.
module tb_linear_layer_start_token_fifo;

  localparam int DW    = 4;
  localparam int AW    = 1;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_write_ce, if_write, if_read_ce, if_read;
  logic [DW-1:0] if_din;
  logic          if_full_n, if_empty_n;
  logic [DW-1:0] if_dout;
`ifdef START_FIFO_OCCUPANCY_EN
  logic [AW:0]   if_num_data_valid;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] mq[$];

  always #5 clk = ~clk;

  linear_layer_start_token_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_write_ce (if_write_ce),
    .if_write    (if_write),
    .if_din      (if_din),
    .if_full_n   (if_full_n),
    .if_read_ce  (if_read_ce),
    .if_read     (if_read),
    .if_dout     (if_dout),
    .if_empty_n  (if_empty_n)
`ifdef START_FIFO_OCCUPANCY_EN
    ,
    .if_num_data_valid (if_num_data_valid)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a token queue, oldest at the front, capacity DEPTH.
  always @(posedge clk or posedge reset) begin : model
    bit pu, po;
    if (reset) begin
      mq.delete();
    end else begin
      pu = if_write && if_write_ce && (mq.size() < DEPTH);
      po = if_read && if_read_ce && (mq.size() > 0);
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(if_din);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_empty_n", {31'd0, if_empty_n}, {31'd0, mq.size() != 0});
      chk("model_full_n", {31'd0, if_full_n}, {31'd0, mq.size() != DEPTH});
      if (mq.size() != 0) chk("model_dout", {28'd0, if_dout}, {28'd0, mq[0]});
`ifdef START_FIFO_OCCUPANCY_EN
      chk("model_num_valid", {30'd0, if_num_data_valid}, mq.size());
`endif
    end
  end

  task automatic step(input logic w, input logic wce, input logic [DW-1:0] d,
                      input logic r, input logic rce);
    if_write = w; if_write_ce = wce; if_din = d; if_read = r; if_read_ce = rce;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    chk("rst_empty_n", {31'd0, if_empty_n}, 32'd0);
    chk("rst_full_n", {31'd0, if_full_n}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    if_write = 0; if_write_ce = 0; if_read = 0; if_read_ce = 0; if_din = '0;
    #2 reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_empty_n", {31'd0, if_empty_n}, 32'd0);
    chk("reset_full_n", {31'd0, if_full_n}, 32'd1);

    // T2 fill/drain
    step(1, 1, 4'h1, 0, 0);
    chk("t2_empty_n_1", {31'd0, if_empty_n}, 32'd1);
    chk("t2_dout_a", {28'd0, if_dout}, 32'h1);
    step(1, 1, 4'h0, 0, 0);
    chk("t2_full_n_2", {31'd0, if_full_n}, 32'd0);
    step(1, 1, 4'h7, 0, 0);
    chk("t2_full_n_3", {31'd0, if_full_n}, 32'd0);
    chk("t2_dout_still_a", {28'd0, if_dout}, 32'h1);
    step(0, 0, '0, 1, 1);
    chk("t2_dout_b", {28'd0, if_dout}, 32'h0);
    chk("t2_full_n_pop", {31'd0, if_full_n}, 32'd1);
    step(0, 0, '0, 1, 1);
    chk("t2_empty_n_end", {31'd0, if_empty_n}, 32'd0);

    // T3 simultaneous at cnt=1
    step(1, 1, 4'h3, 0, 0);
    chk("t3_head", {28'd0, if_dout}, 32'h3);
    step(1, 1, 4'h5, 1, 1);
    chk("t3_dout", {28'd0, if_dout}, 32'h5);
    chk("t3_empty_n", {31'd0, if_empty_n}, 32'd1);
    chk("t3_full_n", {31'd0, if_full_n}, 32'd1);
    step(0, 0, '0, 1, 1);

    // T4 full with push and pop: only the pop is taken
    step(1, 1, 4'h9, 0, 0);
    step(1, 1, 4'hA, 0, 0);
    step(1, 1, 4'hF, 1, 1);
    chk("t4_full_n", {31'd0, if_full_n}, 32'd1);
    chk("t4_dout", {28'd0, if_dout}, 32'hA);
    step(0, 0, '0, 1, 1);
    chk("t4_push_dropped", {31'd0, if_empty_n}, 32'd0);

    // T5 empty with push and pop: only the push is taken
    step(1, 1, 4'h6, 1, 1);
    chk("t5_empty_n", {31'd0, if_empty_n}, 32'd1);
    chk("t5_dout", {28'd0, if_dout}, 32'h6);
    idle();
    chk("t5_kept", {28'd0, if_dout}, 32'h6);
    step(0, 0, '0, 1, 1);

    // T6 clock enables
    repeat (5) step(1, 0, 4'hC, 0, 0);
    chk("t6_wce_blocked", {31'd0, if_empty_n}, 32'd0);
    step(1, 1, 4'h8, 0, 0);
    repeat (3) step(0, 0, '0, 1, 0);
    chk("t6_rce_kept", {31'd0, if_empty_n}, 32'd1);
    chk("t6_rce_dout", {28'd0, if_dout}, 32'h8);
    step(0, 0, '0, 1, 1);

    // T1 reset mid-stream with two tokens held
    step(1, 1, 4'h2, 0, 0);
    step(1, 1, 4'h4, 0, 0);
    pulse_reset();
    step(1, 1, 4'h1, 0, 0);
    chk("t1_empty_n", {31'd0, if_empty_n}, 32'd1);
    chk("t1_dout", {28'd0, if_dout}, 32'h1);
    chk("t1_full_n", {31'd0, if_full_n}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else step(1'($urandom), 1'($urandom_range(0, 3) != 0), 4'($urandom),
                1'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    idle();
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
